// File: rtl/eth_video_pkg.sv
// Shared types for the Ethernet-to-video pixel path.
package eth_video_pkg;

  localparam int unsigned PKG_BPC = 8;

  // One displayed pixel, colour channels in {R,G,B} order.
  typedef struct packed {
    logic [PKG_BPC-1:0] r;
    logic [PKG_BPC-1:0] g;
    logic [PKG_BPC-1:0] b;
  } rgb_t;

  typedef enum logic {
    WAIT_SOF = 1'b0,
    STREAM   = 1'b1
  } vid_state_e;

  // Split a packed 4*BPC pixel word into colours; the lowest BPC bits are padding.
  function automatic rgb_t unpack_pixel(input logic [4*PKG_BPC-1:0] word);
    rgb_t p;
    p.r = word[4*PKG_BPC-1 -: PKG_BPC];
    p.g = word[3*PKG_BPC-1 -: PKG_BPC];
    p.b = word[2*PKG_BPC-1 -: PKG_BPC];
    return p;
  endfunction

endpackage

// File: rtl/eth_pixel_fifo.sv
// Synchronous pixel FIFO: head word is read straight from the storage registers,
// so a word written in cycle n is visible at the head in cycle n+1.
module eth_pixel_fifo #(
  parameter int unsigned WIDTH = 33,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_empty,
  output logic                     o_full,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;
  logic             w_push;
  logic             w_pop;

  assign o_empty = (r_level == '0);
  assign o_full  = (r_level == LW'(DEPTH));
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_rdata = r_mem[r_rd_ptr];
  assign o_level = r_level;

  // Storage write; contents need no reset since level gates visibility.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/eth_pixel_video_gen.sv
// Pixel FIFO to video timing bridge with SOF frame lock, underflow fill and
// resynchronisation on misplaced SOF.
module eth_pixel_video_gen
  import eth_video_pkg::*;
#(
  parameter int unsigned     BPC        = 8,
  parameter int unsigned     FIFO_DEPTH = 2048,
  parameter int unsigned     H_ACTIVE   = 1280,
  parameter int unsigned     H_FP       = 110,
  parameter int unsigned     H_SYNC     = 40,
  parameter int unsigned     H_BP       = 220,
  parameter int unsigned     V_ACTIVE   = 720,
  parameter int unsigned     V_FP       = 5,
  parameter int unsigned     V_SYNC     = 5,
  parameter int unsigned     V_BP       = 20,
  parameter bit              HS_POL     = 1'b1,
  parameter bit              VS_POL     = 1'b1,
  parameter logic [3*BPC-1:0] FILL_RGB  = '0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [4*BPC-1:0]              in_data,
  input  logic                          in_sof,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          clr_flags,
  output logic                          vid_hsync,
  output logic                          vid_vsync,
  output logic                          vid_de,
  output logic [3*BPC-1:0]              vid_rgb,
  output logic                          locked,
  output logic                          underflow,
  output logic                          sof_err,
  output logic [15:0]                   underflow_cnt,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int unsigned W       = 4 * BPC;
  localparam int unsigned CW      = 3 * BPC;
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW      = $clog2(H_TOTAL);
  localparam int unsigned VW      = $clog2(V_TOTAL);

  logic [HW-1:0]  r_h;
  logic [VW-1:0]  r_v;
  vid_state_e     r_state;

  logic [W:0]     w_head;
  logic           w_head_sof;
  logic [CW-1:0]  w_head_rgb;
  logic           w_unused_pad;
  logic           w_empty;
  logic           w_full;
  logic           w_active;
  logic           w_origin;
  logic           w_hs_on;
  logic           w_vs_on;
  logic           w_pop;
  logic           w_uf_set;
  logic           w_se_set;
  logic [CW-1:0]  w_pix;
  vid_state_e     w_next_state;

  eth_pixel_fifo #(
    .WIDTH (W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (in_valid),
    .i_wdata ({in_sof, in_data}),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_empty (w_empty),
    .o_full  (w_full),
    .o_level (fifo_level)
  );

  assign in_ready     = !w_full;
  assign w_head_sof   = w_head[W];
  assign w_head_rgb   = w_head[W-1:BPC];
  assign w_unused_pad = ^w_head[BPC-1:0];

  assign w_active = (r_h < HW'(H_ACTIVE)) && (r_v < VW'(V_ACTIVE));
  assign w_origin = (r_h == '0) && (r_v == '0);
  assign w_hs_on  = (r_h >= HW'(H_ACTIVE + H_FP)) && (r_h < HW'(H_ACTIVE + H_FP + H_SYNC));
  assign w_vs_on  = (r_v >= VW'(V_ACTIVE + V_FP)) && (r_v < VW'(V_ACTIVE + V_FP + V_SYNC));

  // Frame-lock decisions for the current timing position and FIFO head.
  always_comb begin
    w_pop        = 1'b0;
    w_uf_set     = 1'b0;
    w_se_set     = 1'b0;
    w_pix        = FILL_RGB;
    w_next_state = r_state;
    case (r_state)
      WAIT_SOF: begin
        if (!w_empty) begin
          if (!w_head_sof) begin
            w_pop = 1'b1;
          end else if (w_origin) begin
            w_pop        = 1'b1;
            w_pix        = w_head_rgb;
            w_next_state = STREAM;
          end
        end
      end
      STREAM: begin
        if (w_active) begin
          if (w_empty) begin
            w_uf_set = 1'b1;
          end else if (w_head_sof && !w_origin) begin
            // Early SOF: keep the word so it starts the next frame.
            w_se_set     = 1'b1;
            w_next_state = WAIT_SOF;
          end else begin
            w_pop    = 1'b1;
            w_pix    = w_head_rgb;
            w_se_set = w_origin && !w_head_sof;
          end
        end
      end
      default: w_next_state = WAIT_SOF;
    endcase
  end

  // Free-running raster counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_h <= '0;
      r_v <= '0;
    end else if (r_h == HW'(H_TOTAL - 1)) begin
      r_h <= '0;
      r_v <= (r_v == VW'(V_TOTAL - 1)) ? '0 : r_v + VW'(1);
    end else begin
      r_h <= r_h + HW'(1);
    end
  end

  // Lock state and registered video outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= WAIT_SOF;
      locked    <= 1'b0;
      vid_de    <= 1'b0;
      vid_rgb   <= '0;
      vid_hsync <= ~HS_POL;
      vid_vsync <= ~VS_POL;
    end else begin
      r_state   <= w_next_state;
      locked    <= (w_next_state == STREAM);
      vid_de    <= w_active;
      vid_rgb   <= w_active ? w_pix : '0;
      vid_hsync <= w_hs_on ? HS_POL : ~HS_POL;
      vid_vsync <= w_vs_on ? VS_POL : ~VS_POL;
    end
  end

  // Sticky error flags and saturating fill counter; a new event beats a clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      underflow     <= 1'b0;
      sof_err       <= 1'b0;
      underflow_cnt <= '0;
    end else begin
      if (w_uf_set)       underflow <= 1'b1;
      else if (clr_flags) underflow <= 1'b0;

      if (w_se_set)       sof_err <= 1'b1;
      else if (clr_flags) sof_err <= 1'b0;

      if (w_uf_set) begin
        if (underflow_cnt != 16'hFFFF) underflow_cnt <= underflow_cnt + 16'd1;
      end else if (clr_flags) begin
        underflow_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_eth_pixel_video_gen.sv
// Randomized bench for eth_pixel_video_gen against a frame-level reference model.
module tb_eth_pixel_video_gen;

  localparam int unsigned BPC   = 8;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned HA = 8, HFP = 2, HSY = 2, HBP = 2;
  localparam int unsigned VA = 4, VFP = 1, VSY = 1, VBP = 1;
  localparam int unsigned HT = HA + HFP + HSY + HBP;
  localparam int unsigned VT = VA + VFP + VSY + VBP;
  localparam int unsigned FRAME = HT * VT;
  localparam logic [23:0] FILL = 24'h0;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] in_data;
  logic        in_sof;
  logic        in_valid;
  logic        in_ready;
  logic        clr_flags;
  logic        vid_hsync, vid_vsync, vid_de;
  logic [23:0] vid_rgb;
  logic        locked, underflow, sof_err;
  logic [15:0] underflow_cnt;
  logic [4:0]  fifo_level;

  eth_pixel_video_gen #(
    .BPC(BPC), .FIFO_DEPTH(DEPTH),
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
    .HS_POL(1'b1), .VS_POL(1'b1), .FILL_RGB(FILL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_sof(in_sof),
    .in_valid(in_valid), .in_ready(in_ready), .clr_flags(clr_flags),
    .vid_hsync(vid_hsync), .vid_vsync(vid_vsync), .vid_de(vid_de),
    .vid_rgb(vid_rgb), .locked(locked), .underflow(underflow),
    .sof_err(sof_err), .underflow_cnt(underflow_cnt), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          sof;
    logic [31:0] data;
  } word_t;

  word_t feed[$];
  word_t mq[$];

  int n_checks = 0;
  int n_pass   = 0;

  int          m_k;
  bit          m_stream, m_uf, m_se, m_pushed;
  int          m_cnt;
  bit          e_de, e_hs, e_vs, e_locked;
  logic [23:0] e_rgb;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    mq.delete();
    m_k = 0; m_stream = 0; m_uf = 0; m_se = 0; m_cnt = 0;
    e_de = 0; e_hs = 0; e_vs = 0; e_locked = 0; e_rgb = '0;
  endtask

  // One pixel clock of the reference: raster position from the cycle count,
  // pixel source chosen by the lock rules, FIFO kept as a queue of words.
  task automatic model_edge();
    int h, v;
    bit act, org, has, pop, uf, se, nxt;
    word_t hd;
    logic [23:0] px;
    h = m_k % HT;
    v = (m_k / HT) % VT;
    act = (h < HA) && (v < VA);
    org = (h == 0) && (v == 0);
    has = mq.size() > 0;
    hd = '{0, 32'h0};
    if (has) hd = mq[0];
    pop = 0; uf = 0; se = 0; nxt = m_stream; px = FILL;
    if (!m_stream) begin
      if (has && !hd.sof) pop = 1;
      else if (has && org) begin pop = 1; px = hd.data[31:8]; nxt = 1; end
    end else if (act) begin
      if (!has) uf = 1;
      else if (hd.sof && !org) begin se = 1; nxt = 0; end
      else begin
        pop = 1; px = hd.data[31:8];
        if (org && !hd.sof) se = 1;
      end
    end
    m_pushed = in_valid && (mq.size() < DEPTH);
    if (pop) void'(mq.pop_front());
    if (m_pushed) mq.push_back('{in_sof, in_data});
    e_de  = act;
    e_hs  = (h >= HA + HFP) && (h < HA + HFP + HSY);
    e_vs  = (v >= VA + VFP) && (v < VA + VFP + VSY);
    e_rgb = act ? px : 24'h0;
    if (uf) m_uf = 1; else if (clr_flags) m_uf = 0;
    if (se) m_se = 1; else if (clr_flags) m_se = 0;
    if (uf) begin if (m_cnt != 16'hFFFF) m_cnt++; end
    else if (clr_flags) m_cnt = 0;
    m_stream = nxt;
    e_locked = nxt;
    m_k++;
  endtask

  task automatic compare_all();
    check("de",      32'(vid_de),        32'(e_de));
    check("hsync",   32'(vid_hsync),     32'(e_hs));
    check("vsync",   32'(vid_vsync),     32'(e_vs));
    check("rgb",     32'(vid_rgb),       32'(e_rgb));
    check("locked",  32'(locked),        32'(e_locked));
    check("uflow",   32'(underflow),     32'(m_uf));
    check("sof_err", 32'(sof_err),       32'(m_se));
    check("uf_cnt",  32'(underflow_cnt), 32'(m_cnt));
    check("level",   32'(fifo_level),    32'(mq.size()));
    check("ready",   32'(in_ready),      32'(mq.size() < DEPTH));
  endtask

  // Present inputs at the falling edge, advance model and DUT, sample at the next falling edge.
  task automatic step(input int pct, input bit clr);
    bit go;
    go = (feed.size() > 0) && ($urandom_range(0, 99) < pct);
    in_valid  = go;
    in_data   = go ? feed[0].data : $urandom;
    in_sof    = go ? feed[0].sof  : 1'($urandom);
    clr_flags = clr;
    model_edge();
    @(posedge clk);
    if (m_pushed) void'(feed.pop_front());
    @(negedge clk);
    in_valid  = 1'b0;
    clr_flags = 1'b0;
    compare_all();
  endtask

  task automatic add_frame(input int n, input int bad, input bit solid);
    for (int i = 0; i < n; i++)
      feed.push_back('{(i == 0) || (i == bad), solid ? 32'hFF000000 : $urandom});
  endtask

  // Clear flags during horizontal blanking, where no flag can be set.
  task automatic pulse_clr(input int pct);
    int guard = 0;
    while (((m_k % HT) < HA) && (guard < HT)) begin step(pct, 0); guard++; end
    step(pct, 1);
  endtask

  task automatic check_reset(input string p);
    check({p, "_de"},     32'(vid_de),        32'h0);
    check({p, "_rgb"},    32'(vid_rgb),       32'h0);
    check({p, "_hsync"},  32'(vid_hsync),     32'h0);
    check({p, "_vsync"},  32'(vid_vsync),     32'h0);
    check({p, "_ready"},  32'(in_ready),      32'h1);
    check({p, "_locked"}, 32'(locked),        32'h0);
    check({p, "_level"},  32'(fifo_level),    32'h0);
    check({p, "_uflow"},  32'(underflow),     32'h0);
    check({p, "_soferr"}, 32'(sof_err),       32'h0);
    check({p, "_ufcnt"},  32'(underflow_cnt), 32'h0);
  endtask

  initial begin
    rst_n = 1'b0; in_data = '0; in_sof = 1'b0; in_valid = 1'b0; clr_flags = 1'b0;
    repeat (3) @(negedge clk);
    check_reset("rst");
    rst_n = 1'b1;
    model_reset();

    // Junk before the first SOF, then a solid-red frame and random frames.
    for (int i = 0; i < 3; i++) feed.push_back('{0, $urandom});
    add_frame(32, -1, 1);
    for (int f = 0; f < 3; f++) add_frame(32, -1, 0);
    repeat (FRAME * 4) step(100, 0);

    // Short frame starves the display, then flags are cleared.
    pulse_clr(100);
    add_frame(20, -1, 0);
    repeat (FRAME * 2) step(100, 0);
    pulse_clr(100);
    add_frame(32, -1, 0);
    add_frame(32, -1, 0);
    repeat (FRAME * 3) step(100, 0);

    // SOF arriving on the fifth word forces a realign.
    add_frame(32, 4, 0);
    add_frame(32, -1, 0);
    add_frame(32, -1, 0);
    repeat (FRAME * 4) step(100, 0);
    pulse_clr(100);

    // Random frame lengths, misplaced SOFs and input gaps.
    for (int f = 0; f < 5; f++) begin
      int n, bad;
      n   = ($urandom_range(0, 3) == 0) ? $urandom_range(10, 32) : 32;
      bad = ($urandom_range(0, 3) == 0) ? $urandom_range(1, n - 1) : -1;
      add_frame(n, bad, 0);
    end
    repeat (FRAME * 5) step($urandom_range(40, 100), 0);
    pulse_clr(100);

    // Backpressure while the SOF head waits for the frame origin, then reset mid-frame.
    rst_n = 1'b0;
    feed.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    add_frame(32, -1, 0);
    repeat (31) step(100, 0);
    check("bp_level",  32'(fifo_level), 32'd16);
    check("bp_ready",  32'(in_ready),   32'd0);
    check("bp_locked", 32'(locked),     32'd0);
    check("bp_de",     32'(vid_de),     32'd1);
    rst_n = 1'b0;
    #1;
    check_reset("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    feed.delete();
    add_frame(32, -1, 0);
    add_frame(32, -1, 0);
    repeat (FRAME * 3) step(100, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
